// File: rtl/dds_symbol_sequencer.sv
// dds_symbol_sequencer
//   Byte-stream modulation controller placed in front of the DDS wrapper.
//   Bytes are accepted over a valid/ready handshake and serialized MSB-first
//   into 1-bit symbols (ASK/FSK/BPSK/RAW) or 2-bit symbols (QPSK). Each
//   symbol is held for SYMBOL_CYCLES clocks.
//
//   Optional feature: define DDS_SEQ_PREAMBLE_EN to prefix every frame that
//   leaves IDLE with PREAMBLE_BYTE.
//
// Ports
//   clk               in   system clock
//   rst               in   asynchronous, active-low reset
//   mode_cfg   [3:0]  in   requested mode, sampled when a frame starts
//   in_data    [7:0]  in   byte to transmit
//   in_valid          in   in_data is valid
//   in_ready          out  byte accepted when in_valid && in_ready
//   dds_en            out  DDS.en
//   dds_data   [1:0]  out  DDS.data (current symbol)
//   dds_mode   [3:0]  out  DDS.mode
//   dds_fsk_phase_inc out  DDS.fsk_phase_inc (follows dds_data[0])
//   sym_strobe        out  one-cycle pulse on the first cycle of each symbol
//   busy              out  high whenever the sequencer is not IDLE
module dds_symbol_sequencer #(
  parameter int unsigned SYMBOL_CYCLES = 1000,
  parameter logic [31:0] FSK_INC_HI    = 32'd430,
  parameter logic [31:0] FSK_INC_LO    = 32'd86,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
  parameter logic [3:0]  ASK           = 4'b1000,
  parameter logic [3:0]  FSK           = 4'b1001,
  parameter logic [3:0]  BPSK          = 4'b1010,
  parameter logic [3:0]  RAW           = 4'b1011,
  parameter logic [3:0]  QPSK          = 4'b1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode_cfg,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        dds_en,
  output logic [1:0]  dds_data,
  output logic [3:0]  dds_mode,
  output logic [31:0] dds_fsk_phase_inc,
  output logic        sym_strobe,
  output logic        busy
);

  localparam int unsigned CNT_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_SYM  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             dds_en_q, dds_en_d;
  logic [1:0]       dds_data_q, dds_data_d;
  logic [3:0]       dds_mode_q, dds_mode_d;
  logic [31:0]      fsk_inc_q, fsk_inc_d;
  logic             sym_strobe_q, sym_strobe_d;
`ifdef DDS_SEQ_PREAMBLE_EN
  logic [7:0]       byte_q, byte_d;
`endif

  logic cfg_mod, cfg_qpsk, cur_qpsk, sym_last, bit_last;

  // First symbol of a byte: top two bits for QPSK, top bit otherwise.
  function automatic logic [1:0] sym_of(input logic [7:0] b, input logic q);
    return q ? b[7:6] : {1'b0, b[7]};
  endfunction

  function automatic logic [7:0] shift_of(input logic [7:0] b, input logic q);
    return q ? {b[5:0], 2'b00} : {b[6:0], 1'b0};
  endfunction

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    sym_cnt_d    = sym_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    dds_en_d     = dds_en_q;
    dds_data_d   = dds_data_q;
    dds_mode_d   = dds_mode_q;
    sym_strobe_d = 1'b0;
    in_ready     = 1'b0;
`ifdef DDS_SEQ_PREAMBLE_EN
    byte_d       = byte_q;
`endif

    cfg_mod  = (mode_cfg == ASK) || (mode_cfg == FSK) || (mode_cfg == BPSK) ||
               (mode_cfg == RAW) || (mode_cfg == QPSK);
    cfg_qpsk = (mode_cfg == QPSK);
    cur_qpsk = (dds_mode_q == QPSK);
    sym_last = (sym_cnt_q == SYM_LAST);
    bit_last = (bit_cnt_q == (cur_qpsk ? 3'd3 : 3'd7));

    case (state_q)
      ST_IDLE: begin
        dds_data_d = '0;
        if (!cfg_mod) begin
          // Non-modulated modes run the DDS free with the requested mode.
          dds_en_d   = 1'b1;
          dds_mode_d = mode_cfg;
        end else begin
          dds_en_d = 1'b0;
          in_ready = 1'b1;
          if (in_valid) begin
            dds_mode_d   = mode_cfg;
            dds_en_d     = 1'b1;
            sym_strobe_d = 1'b1;
            sym_cnt_d    = '0;
            bit_cnt_d    = '0;
`ifdef DDS_SEQ_PREAMBLE_EN
            byte_d     = in_data;
            dds_data_d = sym_of(PREAMBLE_BYTE, cfg_qpsk);
            shift_d    = shift_of(PREAMBLE_BYTE, cfg_qpsk);
            state_d    = ST_PRE;
`else
            dds_data_d = sym_of(in_data, cfg_qpsk);
            shift_d    = shift_of(in_data, cfg_qpsk);
            state_d    = ST_SYM;
`endif
          end
        end
      end

`ifdef DDS_SEQ_PREAMBLE_EN
      ST_PRE: begin
        if (sym_last) begin
          sym_cnt_d    = '0;
          sym_strobe_d = 1'b1;
          if (bit_last) begin
            dds_data_d = sym_of(byte_q, cur_qpsk);
            shift_d    = shift_of(byte_q, cur_qpsk);
            bit_cnt_d  = '0;
            state_d    = ST_SYM;
          end else begin
            dds_data_d = sym_of(shift_q, cur_qpsk);
            shift_d    = shift_of(shift_q, cur_qpsk);
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
`endif

      ST_SYM: begin
        if (sym_last) begin
          sym_cnt_d = '0;
          if (bit_last) begin
            // Ready only on the final cycle so a waiting byte follows gaplessly.
            in_ready = 1'b1;
            bit_cnt_d = '0;
            if (in_valid) begin
              sym_strobe_d = 1'b1;
              dds_data_d   = sym_of(in_data, cur_qpsk);
              shift_d      = shift_of(in_data, cur_qpsk);
            end else begin
              dds_en_d   = 1'b0;
              dds_data_d = '0;
              state_d    = ST_IDLE;
            end
          end else begin
            sym_strobe_d = 1'b1;
            dds_data_d   = sym_of(shift_q, cur_qpsk);
            shift_d      = shift_of(shift_q, cur_qpsk);
            bit_cnt_d    = bit_cnt_q + 3'd1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    fsk_inc_d = dds_data_d[0] ? FSK_INC_HI : FSK_INC_LO;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      sym_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      dds_en_q     <= 1'b0;
      dds_data_q   <= '0;
      dds_mode_q   <= '0;
      fsk_inc_q    <= FSK_INC_LO;
      sym_strobe_q <= 1'b0;
`ifdef DDS_SEQ_PREAMBLE_EN
      byte_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      dds_en_q     <= dds_en_d;
      dds_data_q   <= dds_data_d;
      dds_mode_q   <= dds_mode_d;
      fsk_inc_q    <= fsk_inc_d;
      sym_strobe_q <= sym_strobe_d;
`ifdef DDS_SEQ_PREAMBLE_EN
      byte_q       <= byte_d;
`endif
    end
  end

  assign dds_en            = dds_en_q;
  assign dds_data          = dds_data_q;
  assign dds_mode          = dds_mode_q;
  assign dds_fsk_phase_inc = fsk_inc_q;
  assign sym_strobe        = sym_strobe_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_symbol_sequencer.sv
module tb_dds_symbol_sequencer;

  localparam logic [3:0] BPSK = 4'b1010;
  localparam logic [3:0] FSK  = 4'b1001;
  localparam logic [3:0] QPSK = 4'b1100;
  localparam logic [31:0] INC_HI = 32'd430;
  localparam logic [31:0] INC_LO = 32'd86;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  mode_cfg;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        dds_en;
  logic [1:0]  dds_data;
  logic [3:0]  dds_mode;
  logic [31:0] dds_fsk_phase_inc;
  logic        sym_strobe;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  dds_symbol_sequencer #(.SYMBOL_CYCLES(4)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .mode_cfg          (mode_cfg),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .dds_en            (dds_en),
    .dds_data          (dds_data),
    .dds_mode          (dds_mode),
    .dds_fsk_phase_inc (dds_fsk_phase_inc),
    .sym_strobe        (sym_strobe),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Symbols packed two bits each, first symbol in s[15:14]. Called on the
  // falling edge inside the first symbol cycle; returns on the falling edge
  // of the cycle after the last symbol.
  task automatic expect_syms(input string tag, input logic [15:0] s, input int n,
                             input logic rdy_last, input logic [3:0] m);
    logic [15:0] cur;
    logic [1:0]  sym;
    cur = s;
    for (int i = 0; i < n; i++) begin
      sym = cur[15:14];
      cur = cur << 2;
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s_en_%0d_%0d", tag, i, j), {31'd0, dds_en}, 32'd1);
        chk($sformatf("%s_data_%0d_%0d", tag, i, j), {30'd0, dds_data}, {30'd0, sym});
        chk($sformatf("%s_inc_%0d_%0d", tag, i, j), dds_fsk_phase_inc, sym[0] ? INC_HI : INC_LO);
        chk($sformatf("%s_stb_%0d_%0d", tag, i, j), {31'd0, sym_strobe}, (j == 0) ? 32'd1 : 32'd0);
        chk($sformatf("%s_mode_%0d_%0d", tag, i, j), {28'd0, dds_mode}, {28'd0, m});
        chk($sformatf("%s_busy_%0d_%0d", tag, i, j), {31'd0, busy}, 32'd1);
        chk($sformatf("%s_rdy_%0d_%0d", tag, i, j), {31'd0, in_ready},
            (rdy_last && i == n - 1 && j == 3) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
  endtask

  // Preamble symbols that precede every frame leaving IDLE.
  task automatic expect_pre(input logic q, input logic [3:0] m);
`ifdef DDS_SEQ_PREAMBLE_EN
    if (q) expect_syms("pre_q", 16'hAA00, 4, 1'b0, m);
    else   expect_syms("pre_b", 16'h4444, 8, 1'b0, m);
`else
    if (q && m == 4'd0) $display("unreachable");
`endif
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_en"},   {31'd0, dds_en},     32'd0);
    chk({tag, "_busy"}, {31'd0, busy},       32'd0);
    chk({tag, "_data"}, {30'd0, dds_data},   32'd0);
    chk({tag, "_stb"},  {31'd0, sym_strobe}, 32'd0);
    chk({tag, "_inc"},  dds_fsk_phase_inc,   INC_LO);
    chk({tag, "_rdy"},  {31'd0, in_ready},   32'd1);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic [3:0] m);
    mode_cfg = m;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy_idle"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    mode_cfg = BPSK;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mode", {28'd0, dds_mode}, 32'd0);
    idle_chk("rst");
    rst = 1'b1;
    @(negedge clk);

    // BPSK 0xA5 -> 1,0,1,0,0,1,0,1
    send_byte("bpsk", 8'hA5, BPSK);
    expect_pre(1'b0, BPSK);
    expect_syms("bpsk", 16'h4411, 8, 1'b1, BPSK);
    idle_chk("bpsk_end");

    // QPSK 0x1B -> 00,01,10,11
    send_byte("qpsk", 8'h1B, QPSK);
    expect_pre(1'b1, QPSK);
    expect_syms("qpsk", 16'h1B00, 4, 1'b1, QPSK);
    idle_chk("qpsk_end");

    // FSK 0x80 -> HI for one symbol, LO for seven
    send_byte("fsk", 8'h80, FSK);
    expect_pre(1'b0, FSK);
    expect_syms("fsk", 16'h4000, 8, 1'b1, FSK);
    idle_chk("fsk_end");

    // Back-to-back 0xFF then 0x00 with valid held; QPSK request mid-frame ignored
    mode_cfg = BPSK;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    #1;
    chk("b2b_rdy_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_data  = 8'h00;
    mode_cfg = QPSK;
    expect_pre(1'b0, BPSK);
    expect_syms("b2b0", 16'h5555, 8, 1'b1, BPSK);
    in_valid = 1'b0;
    expect_syms("b2b1", 16'h0000, 8, 1'b1, BPSK);
    mode_cfg = BPSK;
    #1;
    idle_chk("b2b_end");

    // Reset in the middle of a byte
    send_byte("rstm", 8'hFF, BPSK);
    repeat (9) @(negedge clk);
    chk("rstm_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstm_mode", {28'd0, dds_mode}, 32'd0);
    idle_chk("rstm");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    idle_chk("rstm_after");

    // Preamble frame (or bare byte when the preamble is not compiled in)
    send_byte("pre", 8'h0F, BPSK);
`ifdef DDS_SEQ_PREAMBLE_EN
    expect_syms("pre_aa", 16'h4444, 8, 1'b0, BPSK);
`endif
    expect_syms("pre_0f", 16'h0055, 8, 1'b1, BPSK);
    idle_chk("pre_end");

    // Non-modulated mode passes straight through and refuses bytes
    mode_cfg = 4'b0001;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("pass_rdy",  {31'd0, in_ready}, 32'd0);
    chk("pass_en",   {31'd0, dds_en},   32'd1);
    chk("pass_mode", {28'd0, dds_mode}, 32'd1);
    chk("pass_busy", {31'd0, busy},     32'd0);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_symbol_sequencer.md
# dds_symbol_sequencer

Byte-stream modulation controller in front of the `DDS` wrapper. It accepts bytes over a valid/ready handshake and serializes them MSB-first into symbols of 1 bit (ASK/FSK/BPSK/RAW) or 2 bits (QPSK). It holds each symbol for a programmable number of clocks and drives the DDS `en`, `data`, `mode` and `fsk_phase_inc` inputs. It sits between the transmit byte source and `DDS`.

## Interface
- `SYMBOL_CYCLES`, 1000: clocks per symbol; legal range 2..2^20.
- `FSK_INC_HI`, 32'd430: phase increment for FSK symbol "1".
- `FSK_INC_LO`, 32'd86: phase increment for FSK symbol "0".
- `PREAMBLE_BYTE`, 8'hAA: byte sent before each frame when the preamble is compiled in.
- `ASK`/`FSK`/`BPSK`/`RAW`/`QPSK`, 4'b1000/4'b1001/4'b1010/4'b1011/4'b1100: mode codes, identical to `DDS`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `mode_cfg`  in  4  requested mode; sampled only at frame start.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  byte accepted on a cycle where `in_valid && in_ready`.
- `dds_en`  out  1  to `DDS.en`.
- `dds_data`  out  2  to `DDS.data`.
- `dds_mode`  out  4  to `DDS.mode`.
- `dds_fsk_phase_inc`  out  32  to `DDS.fsk_phase_inc`.
- `sym_strobe`  out  1  one-cycle pulse on the first cycle of every symbol.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine states: IDLE, PRE (preamble symbols), SYM (data symbols).
- **Modulated modes** are ASK, FSK, BPSK, RAW and QPSK.
  - For any other `mode_cfg`, the block stays in IDLE.
  - It holds `in_ready`=0, `dds_mode`=`mode_cfg` and `dds_en`=1, so SINE/COSINE/SAW/SQUARE pass through free-running.
- **IDLE**
  - With a modulated `mode_cfg`: `in_ready`=1, `dds_en`=0, `dds_data`=0.
  - On a handshake, latch the byte and latch `mode_cfg` into `dds_mode`.
  - Go to PRE if the preamble is enabled, otherwise to SYM.
- **Symbol extraction**
  - Bits per symbol `bps` is 2 for QPSK, otherwise 1.
  - The shift register presents `byte[7]` as `dds_data[0]` (1-bit modes, `dds_data[1]`=0), or `byte[7:6]` as `dds_data[1:0]` (QPSK).
  - The register shifts left by `bps` each symbol.
  - A byte is 8 symbols (1-bit modes) or 4 symbols (QPSK).
- **FSK increment**
  - `dds_fsk_phase_inc` = `dds_data[0] ? FSK_INC_HI : FSK_INC_LO`.
  - It is registered together with `dds_data` and is valid in all modes.
- **Symbol timing**
  - A symbol counter runs 0..`SYMBOL_CYCLES`-1.
  - A bit counter counts symbols per byte.
- **Byte-to-byte handover**
  - `in_ready`=1 on the last cycle of the last symbol of a byte in SYM.
  - If a handshake occurs there, the next byte starts on the following cycle with no gap. The latched mode is unchanged.
  - Otherwise the block returns to IDLE.
- **PRE**
  - Sends `PREAMBLE_BYTE` using the same symbol rules, then goes to SYM with the latched byte.
  - `in_ready`=0 throughout PRE.
- `mode_cfg` changes mid-frame are ignored until the next IDLE exit.

## Timing
- **Reset values:**
  - `in_ready`=1, `dds_en`=0, `dds_data`=0, `dds_mode`=4'b0000.
  - `dds_fsk_phase_inc`=`FSK_INC_LO`, `sym_strobe`=0, `busy`=0.
  - State is IDLE.
- **Latency:** handshake at edge T; first symbol on `dds_*` at T+1, with `sym_strobe`=1 and `dds_en`=1 in that cycle.
- **Symbol hold:** each symbol is held exactly `SYMBOL_CYCLES` cycles. All `dds_*` outputs are registered and glitch-free.
- **Frame length:**
  - One byte is 8×`SYMBOL_CYCLES` cycles, or 4×`SYMBOL_CYCLES` in QPSK.
  - The preamble adds the same amount again.
- **End of frame:** `dds_en` and `busy` fall on the cycle after the last symbol's final cycle.
- **Reset mid-symbol:** outputs go to reset values immediately (asynchronously). The in-flight byte is dropped.

## Configuration
- `DDS_SEQ_PREAMBLE_EN` defined: PRE state exists, and every frame leaving IDLE is prefixed by `PREAMBLE_BYTE`.
- Not defined: PRE state and its logic are removed, and IDLE goes directly to SYM.

## Test plan
All scenarios use `SYMBOL_CYCLES`=4 and no preamble unless stated.
- **BPSK single byte:** `mode_cfg`=BPSK, send 0xA5.
  - `dds_data[0]` = 1,0,1,0,0,1,0,1, each for 4 cycles (32 cycles).
  - 8 `sym_strobe` pulses, then `dds_en`=0 and `busy`=0.
- **QPSK single byte:** `mode_cfg`=QPSK, send 0x1B.
  - `dds_data` = 00,01,10,11, each for 4 cycles (16 cycles total).
- **FSK single byte:** `mode_cfg`=FSK, send 0x80.
  - `dds_fsk_phase_inc`=`FSK_INC_HI` for 4 cycles, then `FSK_INC_LO` for 28 cycles.
- **Back-to-back:** `in_valid` held with 0xFF then 0x00.
  - Second handshake on cycle 32 after the first.
  - 64 contiguous symbol cycles with no `dds_en` gap.
  - A `mode_cfg` change to QPSK mid-frame is ignored.
- **Reset mid-frame:** assert `rst`=0 at cycle 10 of a byte.
  - All outputs take reset values the same cycle.
  - After release, `in_ready`=1 and the byte is not resumed.
- **Preamble:** with `DDS_SEQ_PREAMBLE_EN`, BPSK, send 0x0F.
  - Output is 0xAA then 0x0F bits, 64 cycles total.
  - Without the macro: 0x0F only, 32 cycles.
